// File: rtl/mcpu_ctrl_int.sv
// mcpu_ctrl_int: multi-cycle MIPS control FSM with MIO wait timeout,
// level interrupt + eret, overflow write kill. Option macro: OVF_TRAP_EN.
module mcpu_ctrl_int #(
  parameter int unsigned WAIT_MAX    = 15,
  parameter int unsigned WAIT_W      = 4,
  parameter bit          RESET_IE    = 1'b0,
  parameter logic [2:0]  INT_VEC_SEL = 3'b100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MIO_ready,
  input  logic [31:0] Inst_in,
  input  logic        zero,
  input  logic        overflow,
  input  logic        INT,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic        CPU_MIO,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  PCSource,
  output logic [2:0]  ALU_operation,
  output logic        EPCWrite,
  output logic        int_ack,
  output logic        bus_err,
  output logic [4:0]  state_out
);

  typedef enum logic [4:0] {
    S_IF   = 5'd0,
    S_ID   = 5'd1,
    S_MA   = 5'd2,
    S_MR   = 5'd3,
    S_LW   = 5'd4,
    S_MW   = 5'd5,
    S_RX   = 5'd6,
    S_RW   = 5'd7,
    S_BR   = 5'd8,
    S_J    = 5'd9,
    S_IX   = 5'd10,
    S_IW   = 5'd11,
    S_JAL  = 5'd12,
    S_JR   = 5'd13,
    S_LUI  = 5'd14,
    S_INT  = 5'd15,
    S_ERET = 5'd16,
    S_ERR  = 5'd31
  } state_t;

  localparam logic [2:0] A_AND = 3'b000;
  localparam logic [2:0] A_OR  = 3'b001;
  localparam logic [2:0] A_ADD = 3'b010;
  localparam logic [2:0] A_XOR = 3'b011;
  localparam logic [2:0] A_NOR = 3'b100;
  localparam logic [2:0] A_SRL = 3'b101;
  localparam logic [2:0] A_SUB = 3'b110;
  localparam logic [2:0] A_SLT = 3'b111;

`ifdef OVF_TRAP_EN
  localparam bit OVF_TRAP = 1'b1;
`else
  localparam bit OVF_TRAP = 1'b0;
`endif

  state_t            state;
  state_t            nxt;
  state_t            done_nxt;
  logic              ie;
  logic [WAIT_W-1:0] wcnt;
  logic              wait_hit;
  logic              in_wait;

  logic [5:0] op;
  logic [5:0] fn;
  logic       is_r, is_jr, is_lw, is_sw;
  logic       is_beq, is_bne, is_j, is_jal;
  logic       is_lui, is_eret, is_addi;
  logic [2:0] r_alu;
  logic       r_ok;
  logic       r_sgn;
  logic [2:0] i_alu;
  logic       i_ok;
  logic       ovf_r;
  logic       ovf_i;
  logic       unused_ok;

  assign op      = Inst_in[31:26];
  assign fn      = Inst_in[5:0];
  assign is_r    = (op == 6'b000000);
  assign is_jr   = is_r && (fn == 6'b001000);
  assign is_lw   = (op == 6'b100011);
  assign is_sw   = (op == 6'b101011);
  assign is_beq  = (op == 6'b000100);
  assign is_bne  = (op == 6'b000101);
  assign is_j    = (op == 6'b000010);
  assign is_jal  = (op == 6'b000011);
  assign is_lui  = (op == 6'b001111);
  assign is_addi = (op == 6'b001000);
  assign is_eret = (op == 6'b010000) && (fn == 6'b011000);

  assign ovf_r = overflow & r_sgn;
  assign ovf_i = overflow & is_addi;

  assign in_wait  = (state == S_IF) || (state == S_MR) || (state == S_MW);
  assign wait_hit = (WAIT_MAX != 0) && (wcnt == WAIT_W'(WAIT_MAX));
  assign done_nxt = (ie && INT) ? S_INT : S_IF;

  assign CPU_MIO   = MemRead | MemWrite;
  assign state_out = state;
  assign unused_ok = ^{Inst_in[25:6], zero};

  // R-type funct to ALU op; flags signed add/sub for overflow kill
  always_comb begin
    r_alu = A_ADD;
    r_ok  = 1'b0;
    r_sgn = 1'b0;
    unique case (fn)
      6'b100000: begin r_alu = A_ADD; r_ok = 1'b1; r_sgn = 1'b1; end
      6'b100001: begin r_alu = A_ADD; r_ok = 1'b1; end
      6'b100010: begin r_alu = A_SUB; r_ok = 1'b1; r_sgn = 1'b1; end
      6'b100011: begin r_alu = A_SUB; r_ok = 1'b1; end
      6'b100100: begin r_alu = A_AND; r_ok = 1'b1; end
      6'b100101: begin r_alu = A_OR;  r_ok = 1'b1; end
      6'b100110: begin r_alu = A_XOR; r_ok = 1'b1; end
      6'b100111: begin r_alu = A_NOR; r_ok = 1'b1; end
      6'b101010: begin r_alu = A_SLT; r_ok = 1'b1; end
      6'b000010: begin r_alu = A_SRL; r_ok = 1'b1; end
      default:   ;
    endcase
  end

  // I-type ALU opcode to ALU op
  always_comb begin
    i_alu = A_ADD;
    i_ok  = 1'b0;
    unique case (op)
      6'b001000: begin i_alu = A_ADD; i_ok = 1'b1; end
      6'b001010: begin i_alu = A_SLT; i_ok = 1'b1; end
      6'b001100: begin i_alu = A_AND; i_ok = 1'b1; end
      6'b001101: begin i_alu = A_OR;  i_ok = 1'b1; end
      6'b001110: begin i_alu = A_XOR; i_ok = 1'b1; end
      default:   ;
    endcase
  end

  // next state and datapath controls
  always_comb begin
    nxt           = state;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    Branch        = 1'b0;
    RegDst        = 2'b00;
    MemtoReg      = 2'b00;
    ALUSrcB       = 2'b00;
    PCSource      = 3'b000;
    ALU_operation = A_ADD;
    EPCWrite      = 1'b0;
    int_ack       = 1'b0;
    unique case (state)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MIO_ready;
        PCWrite = MIO_ready;
        if (MIO_ready)     nxt = S_ID;
        else if (wait_hit) nxt = S_ERR;
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        unique case (1'b1)
          is_lw, is_sw:   nxt = S_MA;
          is_eret:        nxt = S_ERET;
          is_jr:          nxt = S_JR;
          is_r && r_ok:   nxt = S_RX;
          is_beq, is_bne: nxt = S_BR;
          is_j:           nxt = S_J;
          is_jal:         nxt = S_JAL;
          is_lui:         nxt = S_LUI;
          i_ok:           nxt = S_IX;
          default:        nxt = S_IF;
        endcase
      end
      S_MA: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = is_sw ? S_MW : S_MR;
      end
      S_MR: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MIO_ready)     nxt = S_LW;
        else if (wait_hit) nxt = S_ERR;
      end
      S_LW: begin
        MemtoReg = 2'b01;
        RegWrite = 1'b1;
        nxt      = done_nxt;
      end
      S_MW: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MIO_ready)     nxt = done_nxt;
        else if (wait_hit) nxt = S_ERR;
      end
      S_RX: begin
        ALUSrcA       = 1'b1;
        ALU_operation = r_alu;
        nxt           = S_RW;
      end
      S_RW: begin
        ALUSrcA       = 1'b1;
        ALU_operation = r_alu;
        RegDst        = 2'b01;
        RegWrite      = ~ovf_r;
        nxt           = (OVF_TRAP && ovf_r) ? S_INT : done_nxt;
      end
      S_BR: begin
        ALUSrcA       = 1'b1;
        ALU_operation = A_SUB;
        PCWriteCond   = 1'b1;
        PCSource      = 3'b001;
        Branch        = is_beq;
        nxt           = done_nxt;
      end
      S_J: begin
        PCWrite  = 1'b1;
        PCSource = 3'b010;
        nxt      = done_nxt;
      end
      S_IX: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = 2'b10;
        ALU_operation = i_alu;
        nxt           = S_IW;
      end
      S_IW: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = 2'b10;
        ALU_operation = i_alu;
        RegWrite      = ~ovf_i;
        nxt           = (OVF_TRAP && ovf_i) ? S_INT : done_nxt;
      end
      S_JAL: begin
        RegDst   = 2'b10;
        MemtoReg = 2'b11;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        PCSource = 3'b010;
        nxt      = done_nxt;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 3'b011;
        nxt      = done_nxt;
      end
      S_LUI: begin
        MemtoReg = 2'b10;
        RegWrite = 1'b1;
        nxt      = done_nxt;
      end
      S_INT: begin
        EPCWrite = 1'b1;
        PCWrite  = 1'b1;
        PCSource = INT_VEC_SEL;
        int_ack  = 1'b1;
        nxt      = S_IF;
      end
      S_ERET: begin
        PCWrite  = 1'b1;
        PCSource = 3'b101;
        nxt      = S_IF;
      end
      S_ERR: nxt = S_ERR;
      default: nxt = S_IF;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IF;
    else        state <= nxt;
  end

  // interrupt enable: cleared on entry, set by eret
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                ie <= RESET_IE;
    else if (state == S_INT)   ie <= 1'b0;
    else if (state == S_ERET)  ie <= 1'b1;
  end

  // wait counter: counts held cycles in IF/MR/MW
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      wcnt <= '0;
    else if (in_wait && nxt == state) wcnt <= wcnt + WAIT_W'(1);
    else                             wcnt <= '0;
  end

  // sticky bus error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          bus_err <= 1'b0;
    else if (nxt == S_ERR) bus_err <= 1'b1;
  end

endmodule

// File: tb/tb_mcpu_ctrl_int.sv
// tb_mcpu_ctrl_int: scoreboard bench for mcpu_ctrl_int.
// Per-cycle expectations queued by stimulus, checked by a monitor.
module tb_mcpu_ctrl_int;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MIO_ready = 1'b0;
  logic [31:0] Inst_in = '0;
  logic        zero = 1'b0;
  logic        overflow = 1'b0;
  logic        INT = 1'b0;
  logic        MemRead, MemWrite, IorD, IRWrite, RegWrite;
  logic        ALUSrcA, PCWrite, PCWriteCond, Branch, CPU_MIO;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB;
  logic [2:0]  PCSource, ALU_operation;
  logic        EPCWrite, int_ack, bus_err;
  logic [4:0]  state_out;

  mcpu_ctrl_int dut (
    .clk(clk), .reset(reset), .MIO_ready(MIO_ready),
    .Inst_in(Inst_in), .zero(zero), .overflow(overflow), .INT(INT),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
    .CPU_MIO(CPU_MIO), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALU_operation(ALU_operation), .EPCWrite(EPCWrite),
    .int_ack(int_ack), .bus_err(bus_err), .state_out(state_out)
  );

  always #5 clk = ~clk;

  localparam int P_MIO = 0, P_MR = 1, P_MW = 2, P_IORD = 3, P_IRW = 4;
  localparam int P_RW = 5, P_SA = 6, P_PCW = 7, P_PCWC = 8, P_BR = 9;
  localparam int P_RD = 10, P_M2R = 12, P_SB = 14, P_PCS = 16;
  localparam int P_ALU = 19, P_EPC = 22, P_ACK = 23, P_BE = 24, P_ST = 25;

  localparam logic [29:0] M_MIO  = 30'h1 << P_MIO;
  localparam logic [29:0] M_MR   = 30'h1 << P_MR;
  localparam logic [29:0] M_MW   = 30'h1 << P_MW;
  localparam logic [29:0] M_IORD = 30'h1 << P_IORD;
  localparam logic [29:0] M_IRW  = 30'h1 << P_IRW;
  localparam logic [29:0] M_RW   = 30'h1 << P_RW;
  localparam logic [29:0] M_SA   = 30'h1 << P_SA;
  localparam logic [29:0] M_PCW  = 30'h1 << P_PCW;
  localparam logic [29:0] M_PCWC = 30'h1 << P_PCWC;
  localparam logic [29:0] M_BR   = 30'h1 << P_BR;
  localparam logic [29:0] M_RD   = 30'h3 << P_RD;
  localparam logic [29:0] M_M2R  = 30'h3 << P_M2R;
  localparam logic [29:0] M_SB   = 30'h3 << P_SB;
  localparam logic [29:0] M_PCS  = 30'h7 << P_PCS;
  localparam logic [29:0] M_ALU  = 30'h7 << P_ALU;
  localparam logic [29:0] M_EPC  = 30'h1 << P_EPC;
  localparam logic [29:0] M_ACK  = 30'h1 << P_ACK;
  localparam logic [29:0] M_BE   = 30'h1 << P_BE;
  localparam logic [29:0] M_ST   = 30'h1F << P_ST;

  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_LW   = 32'h8C22_0000;
  localparam logic [31:0] I_SW   = 32'hAC22_0000;
  localparam logic [31:0] I_BEQ  = 32'h1022_0001;
  localparam logic [31:0] I_BNE  = 32'h1422_0001;
  localparam logic [31:0] I_J    = 32'h0800_0010;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_JR   = 32'h03E0_0008;
  localparam logic [31:0] I_ADDI = 32'h2022_0005;
  localparam logic [31:0] I_LUI  = 32'h3C02_0001;
  localparam logic [31:0] I_ERET = 32'h4200_0018;
  localparam logic [31:0] I_BAD  = 32'hFC00_0000;

  typedef struct {
    string       nm;
    logic [29:0] v;
    logic [29:0] m;
  } exp_t;

  exp_t        q[$];
  logic [31:0] cur = '0;
  int          checks = 0;
  int          failures = 0;
  logic [29:0] act;

  assign act = {state_out, bus_err, int_ack, EPCWrite, ALU_operation,
                PCSource, ALUSrcB, MemtoReg, RegDst, Branch, PCWriteCond,
                PCWrite, ALUSrcA, RegWrite, IRWrite, IorD, MemWrite,
                MemRead, CPU_MIO};

  function automatic logic [29:0] f(input int lsb, input int val);
    return 30'(val) << lsb;
  endfunction

  task automatic cyc(input string nm, input logic [29:0] v,
                     input logic [29:0] m, input logic rdy = 1'b1,
                     input logic intr = 1'b0, input logic ovf = 1'b0,
                     input logic zr = 1'b0, input logic rst = 1'b1);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    MIO_ready = rdy;
    INT       = intr;
    overflow  = ovf;
    zero      = zr;
    Inst_in   = cur;
    e.nm = nm;
    e.v  = v;
    e.m  = m;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if ((act & e.m) !== (e.v & e.m)) begin
          failures++;
          $display("FAIL %s: got %h need %h (mask %h)",
                   e.nm, act & e.m, e.v & e.m, e.m);
        end
      end
    end
  end

  initial begin : stim
    cur = I_ADD;
    cyc("rst", f(P_ST, 0) | f(P_MR, 1) | f(P_SB, 1),
        M_ST | M_BE | M_MR | M_SB | M_IRW | M_PCW | M_RW, 0, 0, 0, 0, 0);

    cyc("add_if", f(P_ST, 0) | f(P_IRW, 1) | f(P_PCW, 1) | f(P_MR, 1)
        | f(P_SB, 1) | f(P_ALU, 2),
        M_ST | M_IRW | M_PCW | M_MR | M_SB | M_ALU | M_RW);
    cyc("add_id", f(P_ST, 1) | f(P_SB, 3), M_ST | M_SB);
    cyc("add_rx", f(P_ST, 6) | f(P_ALU, 2) | f(P_SA, 1),
        M_ST | M_ALU | M_SA | M_RW);
    cyc("add_rw", f(P_ST, 7) | f(P_RW, 1) | f(P_RD, 1),
        M_ST | M_RW | M_RD | M_M2R);

    cur = I_LW;
    cyc("lw_if", f(P_ST, 0) | f(P_IRW, 1), M_ST | M_IRW | M_RW);
    cyc("lw_id", f(P_ST, 1), M_ST);
    cyc("lw_ma", f(P_ST, 2) | f(P_SA, 1) | f(P_SB, 2), M_ST | M_SA | M_SB);
    for (int i = 0; i < 3; i++)
      cyc("lw_mr_wait", f(P_ST, 3) | f(P_MR, 1) | f(P_IORD, 1) | f(P_MIO, 1),
          M_ST | M_MR | M_IORD | M_MIO | M_IRW | M_BE, 0);
    cyc("lw_mr_rdy", f(P_ST, 3) | f(P_MR, 1) | f(P_IORD, 1),
        M_ST | M_MR | M_IORD);
    cyc("lw_wb", f(P_ST, 4) | f(P_RW, 1) | f(P_M2R, 1),
        M_ST | M_RW | M_M2R | M_RD | M_BE);

    cur = I_ERET;
    cyc("eret_if", f(P_ST, 0), M_ST);
    cyc("eret_id", f(P_ST, 1), M_ST);
    cyc("eret_ex", f(P_ST, 16) | f(P_PCW, 1) | f(P_PCS, 5),
        M_ST | M_PCW | M_PCS | M_ACK, 1, 1);

    cur = I_SW;
    cyc("sw_if_noint", f(P_ST, 0), M_ST | M_ACK, 1, 1);
    cyc("sw_id", f(P_ST, 1), M_ST, 1, 1);
    cyc("sw_ma", f(P_ST, 2), M_ST, 1, 1);
    cyc("sw_mw", f(P_ST, 5) | f(P_MW, 1) | f(P_IORD, 1) | f(P_MIO, 1),
        M_ST | M_MW | M_IORD | M_MIO | M_MR, 1, 1);
    cyc("int_entry", f(P_ST, 15) | f(P_EPC, 1) | f(P_PCW, 1) | f(P_ACK, 1)
        | f(P_PCS, 4), M_ST | M_EPC | M_PCW | M_ACK | M_PCS, 1, 1);

    cur = I_BEQ;
    cyc("ack_one_cycle", f(P_ST, 0), M_ST | M_ACK | M_EPC, 1, 1);
    cyc("beq_id", f(P_ST, 1), M_ST, 1, 1);
    cyc("beq_br", f(P_ST, 8) | f(P_PCWC, 1) | f(P_BR, 1) | f(P_PCS, 1)
        | f(P_ALU, 6) | f(P_SA, 1),
        M_ST | M_PCWC | M_BR | M_PCS | M_ALU | M_SA, 1, 1, 0, 1);

    cur = I_ERET;
    cyc("ie0_int_ignored", f(P_ST, 0), M_ST | M_ACK, 1, 1);
    cyc("eret2_id", f(P_ST, 1), M_ST);
    cyc("eret2_ex", f(P_ST, 16), M_ST);

    cur = I_ADD;
    cyc("add2_if", f(P_ST, 0), M_ST);
    cyc("add2_id", f(P_ST, 1), M_ST, 1, 1);
    cyc("add2_rx", f(P_ST, 6), M_ST, 1, 1);
    cyc("add2_rw", f(P_ST, 7) | f(P_RW, 1), M_ST | M_RW, 1, 0);

    cyc("int_drop_ignored", f(P_ST, 0), M_ST | M_ACK);
    cyc("ovf_id", f(P_ST, 1), M_ST);
    cyc("ovf_rx", f(P_ST, 6), M_ST, 1, 0, 1);
    cyc("ovf_rw_kill", f(P_ST, 7) | f(P_RD, 1), M_ST | M_RW | M_RD, 1, 0, 1);
`ifdef OVF_TRAP_EN
    cyc("ovf_trap", f(P_ST, 15) | f(P_ACK, 1) | f(P_EPC, 1),
        M_ST | M_ACK | M_EPC);
`endif

    cur = I_ADDI;
    cyc("addi_if", f(P_ST, 0), M_ST | M_ACK);
    cyc("addi_id", f(P_ST, 1), M_ST);
    cyc("addi_ix", f(P_ST, 10) | f(P_SA, 1) | f(P_SB, 2) | f(P_ALU, 2),
        M_ST | M_SA | M_SB | M_ALU);
    cyc("addi_iw", f(P_ST, 11) | f(P_RW, 1), M_ST | M_RW | M_RD | M_M2R);

    cur = I_BNE;
    cyc("bne_if", f(P_ST, 0), M_ST);
    cyc("bne_id", f(P_ST, 1), M_ST);
    cyc("bne_br", f(P_ST, 8) | f(P_PCWC, 1) | f(P_PCS, 1),
        M_ST | M_PCWC | M_BR | M_PCS);

    cur = I_JAL;
    cyc("jal_if", f(P_ST, 0), M_ST);
    cyc("jal_id", f(P_ST, 1), M_ST);
    cyc("jal_ex", f(P_ST, 12) | f(P_RD, 2) | f(P_M2R, 3) | f(P_RW, 1)
        | f(P_PCW, 1) | f(P_PCS, 2),
        M_ST | M_RD | M_M2R | M_RW | M_PCW | M_PCS);

    cur = I_JR;
    cyc("jr_if", f(P_ST, 0), M_ST);
    cyc("jr_id", f(P_ST, 1), M_ST);
    cyc("jr_ex", f(P_ST, 13) | f(P_PCW, 1) | f(P_PCS, 3),
        M_ST | M_PCW | M_PCS | M_RW);

    cur = I_LUI;
    cyc("lui_if", f(P_ST, 0), M_ST);
    cyc("lui_id", f(P_ST, 1), M_ST);
    cyc("lui_ex", f(P_ST, 14) | f(P_RW, 1) | f(P_M2R, 2),
        M_ST | M_RW | M_M2R | M_RD);

    cur = I_BAD;
    cyc("bad_if", f(P_ST, 0), M_ST);
    cyc("bad_id", f(P_ST, 1), M_ST);

    cur = I_J;
    cyc("nop_back_if", f(P_ST, 0) | f(P_MR, 1), M_ST | M_MR | M_IRW, 0);
    for (int i = 1; i < 15; i++)
      cyc("if_wait", f(P_ST, 0), M_ST | M_IRW | M_PCW | M_BE, 0);
    cyc("if_rdy_at_max", f(P_ST, 0) | f(P_IRW, 1), M_ST | M_IRW | M_BE, 1);
    cyc("j_id", f(P_ST, 1), M_ST | M_BE);
    cyc("j_ex", f(P_ST, 9) | f(P_PCW, 1) | f(P_PCS, 2), M_ST | M_PCW | M_PCS);

    for (int i = 0; i < 16; i++)
      cyc("to_wait", f(P_ST, 0), M_ST | M_BE | M_IRW, 0);
    cyc("to_err", f(P_ST, 31) | f(P_BE, 1),
        M_ST | M_BE | M_MR | M_PCW | M_IRW | M_RW, 0);
    cyc("to_sticky", f(P_ST, 31) | f(P_BE, 1), M_ST | M_BE | M_IRW, 1);
    cyc("err_reset", f(P_ST, 0), M_ST | M_BE, 0, 0, 0, 0, 0);
    cyc("post_reset", f(P_ST, 0) | f(P_IRW, 1), M_ST | M_BE | M_IRW, 1);

    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending need 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
